// File: rtl/plugin_mmio_queue.sv
// MMIO job queue in front of an ALU. A job's result is readable LATENCY+2 edges after its CMD write.
// A CMD write to a full job FIFO drops the job and sets sticky OVF. PLUGIN_MMIO_IRQ_EN enables IRQCTL and irq_o.
module plugin_mmio_queue #(
  parameter logic [31:0] BASE_ADDR = 32'h10000000,
  parameter int          DEPTH     = 4,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [2:0] R_OPA    = 3'd0;
  localparam logic [2:0] R_OPB    = 3'd1;
  localparam logic [2:0] R_CMD    = 3'd2;
  localparam logic [2:0] R_RESULT = 3'd3;
  localparam logic [2:0] R_STATUS = 3'd4;
  localparam logic [2:0] R_IRQCTL = 3'd5;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } job_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  logic [31:0]   opa_q, opa_d, opb_q, opb_d;
  job_t          job_mem_q [DEPTH];
  job_t          job_mem_d [DEPTH];
  logic [PW-1:0] job_wptr_q, job_wptr_d, job_rptr_q, job_rptr_d;
  logic [CW-1:0] job_cnt_q, job_cnt_d;
  logic [31:0]   res_mem_q [DEPTH];
  logic [31:0]   res_mem_d [DEPTH];
  logic [PW-1:0] res_wptr_q, res_wptr_d, res_rptr_q, res_rptr_d;
  logic [CW-1:0] res_cnt_q, res_cnt_d;
  state_t        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  job_t          exec_q, exec_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;

  logic [29:0] off;
  logic [2:0]  sel;
  logic        hit, wr_en, rd_en;
  logic        job_full, job_empty, res_full, res_empty, busy;
  logic        job_push, ovf_set, dispatch, res_push, res_rd, res_pop, udf_set;
  logic [31:0] alu_res, status;
  logic [4:0]  res_cnt5;
  logic        irq_en_rd;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr_i[1:0];

  // Word-granular decode: only addr_i[31:2] takes part.
  always_comb begin
    off   = addr_i[31:2] - BASE_ADDR[31:2];
    hit   = off < 30'd6;
    sel   = off[2:0];
    wr_en = enable_i && (we_i != 4'd0) && hit;
    rd_en = enable_i && (we_i == 4'd0) && hit;
  end

  always_comb begin
    job_full  = job_cnt_q == FULL_CNT;
    job_empty = job_cnt_q == '0;
    res_full  = res_cnt_q == FULL_CNT;
    res_empty = res_cnt_q == '0;
    busy      = state_q != S_IDLE;
    job_push  = wr_en && sel == R_CMD && !job_full;
    ovf_set   = wr_en && sel == R_CMD && job_full;
    // A slot in the result FIFO is reserved for every job in flight.
    dispatch  = state_q == S_IDLE && !job_empty && (res_cnt_q + CW'(busy)) < FULL_CNT;
    res_push  = state_q == S_WB;
    res_rd    = rd_en && sel == R_RESULT;
    res_pop   = res_rd && !res_empty;
    udf_set   = res_rd && res_empty;
  end

  always_comb begin
    alu_res = '0;
    case (exec_q.op)
      3'd0: alu_res = exec_q.a + exec_q.b;
      3'd1: alu_res = exec_q.a - exec_q.b;
      3'd2: alu_res = exec_q.a & exec_q.b;
      3'd3: alu_res = exec_q.a | exec_q.b;
      3'd4: alu_res = exec_q.a ^ exec_q.b;
      3'd5: alu_res = exec_q.a << exec_q.b[4:0];
      3'd6: alu_res = exec_q.a >> exec_q.b[4:0];
      3'd7: alu_res = {31'b0, exec_q.a < exec_q.b};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    opa_d      = opa_q;
    opb_d      = opb_q;
    job_mem_d  = job_mem_q;
    job_wptr_d = job_wptr_q;
    job_rptr_d = job_rptr_q;
    job_cnt_d  = job_cnt_q + CW'(job_push) - CW'(dispatch);
    res_mem_d  = res_mem_q;
    res_wptr_d = res_wptr_q;
    res_rptr_d = res_rptr_q;
    res_cnt_d  = res_cnt_q + CW'(res_push) - CW'(res_pop);
    state_d    = state_q;
    cnt_d      = cnt_q;
    exec_d     = exec_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;

    if (wr_en && sel == R_OPA) opa_d = data_i;
    if (wr_en && sel == R_OPB) opb_d = data_i;
    if (job_push) begin
      job_mem_d[job_wptr_q] = '{a: opa_q, b: opb_q, op: data_i[2:0]};
      job_wptr_d = job_wptr_q + PW'(1);
    end
    if (dispatch) job_rptr_d = job_rptr_q + PW'(1);
    if (res_push) begin
      res_mem_d[res_wptr_q] = alu_res;
      res_wptr_d = res_wptr_q + PW'(1);
    end
    if (res_pop) res_rptr_d = res_rptr_q + PW'(1);

    case (state_q)
      S_IDLE: if (dispatch) begin
        state_d = S_EXEC;
        cnt_d   = LW'(LATENCY - 1);
        exec_d  = job_mem_q[job_rptr_q];
      end
      S_EXEC: if (cnt_q == '0) state_d = S_WB;
              else cnt_d = cnt_q - LW'(1);
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wr_en && sel == R_STATUS && data_i[5]) ovf_d = 1'b0;
    if (wr_en && sel == R_STATUS && data_i[6]) udf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    if (udf_set) udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa_q      <= '0;
      opb_q      <= '0;
      job_mem_q  <= '{default: '0};
      job_wptr_q <= '0;
      job_rptr_q <= '0;
      job_cnt_q  <= '0;
      res_mem_q  <= '{default: '0};
      res_wptr_q <= '0;
      res_rptr_q <= '0;
      res_cnt_q  <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      exec_q     <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      job_mem_q  <= job_mem_d;
      job_wptr_q <= job_wptr_d;
      job_rptr_q <= job_rptr_d;
      job_cnt_q  <= job_cnt_d;
      res_mem_q  <= res_mem_d;
      res_wptr_q <= res_wptr_d;
      res_rptr_q <= res_rptr_d;
      res_cnt_q  <= res_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      exec_q     <= exec_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

`ifdef PLUGIN_MMIO_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_en && sel == R_IRQCTL) irq_en_d = data_i[0];
    irq_d = irq_en_q && (!res_empty || ovf_q || udf_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en_rd = irq_en_q;
  assign irq_o     = irq_q;
`else
  assign irq_en_rd = 1'b0;
  assign irq_o     = 1'b0;
`endif

  always_comb begin
    res_cnt5 = 5'(res_cnt_q);
    status   = {19'b0, res_cnt5, 1'b0, udf_q, ovf_q, res_full, !res_empty,
                job_empty, job_full, busy};
  end

  always_comb begin
    data_o = '0;
    if (rd_en) begin
      case (sel)
        R_OPA:    data_o = opa_q;
        R_OPB:    data_o = opb_q;
        R_RESULT: data_o = res_empty ? 32'h0 : res_mem_q[res_rptr_q];
        R_STATUS: data_o = status;
        R_IRQCTL: data_o = {31'b0, irq_en_rd};
        default:  data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_plugin_mmio_queue.sv
// Directed bench for plugin_mmio_queue; expected results are queued when a CMD is issued and popped on RESULT reads.
module tb_plugin_mmio_queue;
  localparam logic [31:0] BASE   = 32'h10000000;
  localparam int          DEPTH  = 4;
  localparam int          LAT    = 2;
  localparam logic [31:0] A_OPA  = BASE;
  localparam logic [31:0] A_OPB  = BASE + 32'h4;
  localparam logic [31:0] A_CMD  = BASE + 32'h8;
  localparam logic [31:0] A_RES  = BASE + 32'hC;
  localparam logic [31:0] A_STAT = BASE + 32'h10;
  localparam logic [31:0] A_IRQ  = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable_i;
  logic [3:0]  we_i;
  logic [31:0] addr_i, data_i, data_o;
  logic        irq_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];

  logic [31:0] ta [9] = '{32'h80000000, 32'h1, 32'h1, 32'hF0F0F0F0, 32'hF0F0F0F0,
                          32'hF0F0F0F0, 32'h80000000, 32'h3, 32'h5};
  logic [31:0] tb_ [9] = '{32'h80000000, 32'h2, 32'h23, 32'h0FF00FF0, 32'h0FF00FF0,
                           32'h0FF00FF0, 32'h1F, 32'h5, 32'h3};
  logic [2:0]  top [9] = '{3'd0, 3'd1, 3'd5, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd7};

  always #5 clk = ~clk;

  plugin_mmio_queue #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .we_i(we_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .irq_o(irq_o)
  );

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    enable_i = 1'b1; we_i = be; addr_i = a; data_i = d;
    @(posedge clk); #1;
    enable_i = 1'b0; we_i = 4'h0; addr_i = '0; data_i = '0;
  endtask

  // Samples data_o mid-cycle, then drops the strobe before the edge so nothing is popped.
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    enable_i = 1'b1; we_i = 4'h0; addr_i = a;
    #2 d = data_o;
    enable_i = 1'b0; addr_i = '0;
    @(posedge clk); #1;
  endtask

  task automatic rd_result(input string tag);
    logic [31:0] exp;
    exp = (sb.size() > 0) ? sb.pop_front() : 32'h0;
    enable_i = 1'b1; we_i = 4'h0; addr_i = A_RES;
    #2 check(tag, data_o, exp);
    @(posedge clk); #1;
    enable_i = 1'b0; addr_i = '0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    wr(A_OPA, a);
    wr(A_OPB, b);
    sb.push_back(model(a, b, op));
    wr(A_CMD, 32'(op));
  endtask

  initial begin
    logic [31:0] v;
    reset_n = 1'b0; enable_i = 1'b0; we_i = 4'h0; addr_i = '0; data_i = '0;
    idle(2);
    check("rst_data_o", data_o, 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    peek(A_STAT, v); check("rst_status", v, 32'h4);
    reset_n = 1'b1;
    idle(1);

    // Single ADD, with the exact cycle the result becomes visible.
    issue(32'd5, 32'd7, 3'd0);
    idle(LAT + 1);
    peek(A_STAT, v); check("lat_status_wb", v, 32'h5);
    peek(A_STAT, v); check("lat_status_valid", v, 32'h10C);
    rd_result("add_5_7");
    peek(A_STAT, v); check("status_after_pop", v, 32'h4);
    check("irq_idle", 32'(irq_o), 32'h0);

    for (int i = 0; i < 9; i++) begin
      issue(ta[i], tb_[i], top[i]);
      idle(LAT + 2);
      rd_result($sformatf("op_table_%0d", i));
    end

    // Ten back-to-back CMDs with no reads: jobs 5, 7, 8, 9 arrive while the job FIFO is full.
    wr(A_OPA, 32'h0000F0F0);
    wr(A_OPB, 32'h00000FF3);
    for (int i = 0; i < 10; i++) begin
      if (i != 5 && i != 7 && i != 8 && i != 9)
        sb.push_back(model(32'h0000F0F0, 32'h00000FF3, 3'(i % 8)));
      wr(A_CMD, 32'(i % 8));
    end
    idle(12);
    peek(A_STAT, v); check("ovf_status_full", v, 32'h438);
    for (int i = 0; i < 4; i++) rd_result($sformatf("ovf_res_%0d", i));
    idle(12);
    for (int i = 4; i < 6; i++) rd_result($sformatf("ovf_res_%0d", i));
    peek(A_STAT, v); check("ovf_status_drained", v, 32'h24);

    rd_result("udf_read");
    peek(A_STAT, v); check("udf_status", v, 32'h64);
    wr(A_STAT, 32'h60);
    peek(A_STAT, v); check("w1c_both", v, 32'h4);
    rd_result("udf_read2");
    wr(A_STAT, 32'h20);
    peek(A_STAT, v); check("w1c_ovf_only", v, 32'h44);
    wr(A_STAT, 32'h40);
    peek(A_STAT, v); check("w1c_udf", v, 32'h4);

    wr(BASE + 32'h3, 32'hDEADBEEF, 4'b0001);
    peek(A_OPA, v); check("opa_partial_we", v, 32'hDEADBEEF);
    wr(BASE + 32'h18, 32'h1);
    peek(A_OPA, v); check("opa_after_oow", v, 32'hDEADBEEF);
    peek(BASE + 32'h18, v); check("oow_read_hi", v, 32'h0);
    peek(BASE - 32'h4, v); check("oow_read_lo", v, 32'h0);
    peek(A_CMD, v); check("cmd_reads_0", v, 32'h0);
    wr(BASE + 32'h28, 32'h0);
    peek(A_STAT, v); check("alias_no_push", v, 32'h4);

    // Reset while the engine is in EXEC.
    wr(A_OPA, 32'd9);
    wr(A_OPB, 32'd9);
    wr(A_CMD, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1 check("rst_exec_data_o", data_o, 32'h0);
    peek(A_STAT, v); check("rst_exec_status", v, 32'h4);
    peek(A_OPA, v); check("rst_exec_opa", v, 32'h0);
    reset_n = 1'b1;
    idle(8);
    peek(A_STAT, v); check("rst_exec_no_result", v, 32'h4);

`ifdef PLUGIN_MMIO_IRQ_EN
    wr(A_IRQ, 32'h1);
    peek(A_IRQ, v); check("irqctl_rb", v, 32'h1);
    issue(32'd2, 32'd3, 3'd4);
    idle(LAT + 2);
    check("irq_before", 32'(irq_o), 32'h0);
    peek(A_STAT, v); check("irq_status", v, 32'h10C);
    check("irq_rise", 32'(irq_o), 32'h1);
    rd_result("irq_result");
    check("irq_hold", 32'(irq_o), 32'h1);
    idle(1);
    check("irq_fall", 32'(irq_o), 32'h0);
`else
    wr(A_IRQ, 32'h1);
    peek(A_IRQ, v); check("irqctl_rb", v, 32'h0);
    issue(32'd2, 32'd3, 3'd4);
    idle(LAT + 3);
    check("irq_tied_valid", 32'(irq_o), 32'h0);
    rd_result("irq_result");
    check("irq_tied_after", 32'(irq_o), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/plugin_mmio_queue.md
PLUGIN_MMIO_QUEUE -- requirements
Module: plugin_mmio_queue

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h10000000: base of the 6-word register window.
REQ-002 SHALL have parameter DEPTH, default 4, power of 2, range 2-16: entries in each of the job FIFO and the result FIFO.
REQ-003 SHALL have parameter LATENCY, default 2, minimum 1: execute cycles per job.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have ports enable_i (input, 1), we_i (input, 4), addr_i (input, 32) and data_i (input, 32): bus access strobe, byte-write enables, address and write data.
REQ-007 SHALL have ports data_o (output, 32): combinational read data; and irq_o (output, 1): interrupt request.

Function
REQ-008 Bus cycle: write = enable_i && we_i!=0, treated as a full-word write regardless of which bytes are enabled; read = enable_i && we_i==0.
REQ-009 Decode SHALL compare addr_i[31:2] against the window and ignore addr_i[1:0]; outside the window, writes have no effect and data_o=0.
REQ-010 Register map (offsets from BASE_ADDR):
- 0x00 OPA (R/W)
- 0x04 OPB (R/W)
- 0x08 CMD (W only; reads 0)
- 0x0C RESULT (R, pops)
- 0x10 STATUS
- 0x14 IRQCTL
REQ-011 CMD write SHALL push job {OPA, OPB, data_i[2:0]} into the job FIFO; OPA and OPB are snapshotted at that edge.
REQ-012 Op codes SHALL be 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL by OPB[4:0], 6 SRL by OPB[4:0], 7 SLTU (result 1/0); all results 32-bit with wrap-around.
REQ-013 CMD write with job FIFO full SHALL drop the job and set sticky OVF; fullness is evaluated before any same-cycle engine pop.
REQ-014 Engine FSM SHALL have states IDLE, EXEC and WB.
- IDLE->EXEC when job FIFO not empty and result-FIFO count + in-flight < DEPTH; pops the job and loads cnt=LATENCY-1.
- EXEC: decrements cnt; goes to WB on the edge where cnt==0.
- WB: pushes the result; goes to IDLE.
REQ-015 Latency: a CMD written at edge E into an idle, empty engine SHALL make its result readable after edge E+LATENCY+2.
REQ-016 Jobs SHALL complete strictly in FIFO order, and results SHALL never be lost because space is reserved at dispatch.
REQ-017 RESULT read SHALL return the head of the result FIFO combinationally and pop it at the clock edge.
REQ-018 RESULT read with the result FIFO empty SHALL return 32'h0 and set sticky UDF.
REQ-019 A same-cycle RESULT pop and WB push SHALL leave the result count unchanged and keep the data ordered.
REQ-020 STATUS read SHALL return:
- bit0 busy (FSM!=IDLE)
- bit1 job_full
- bit2 job_empty
- bit3 res_valid
- bit4 res_full
- bit5 OVF
- bit6 UDF
- bits[12:8] result count
- other bits 0
REQ-021 STATUS write SHALL clear OVF when data_i[5]=1 and clear UDF when data_i[6]=1 (W1C); all other bits SHALL be read-only.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; counts SHALL range 0..DEPTH.

Reset
REQ-023 reset_n low SHALL asynchronously clear:
- OPA, OPB
- both FIFOs' pointers and counts
- FSM to IDLE, cnt
- OVF, UDF
- IRQCTL
REQ-024 Reset during EXEC or WB SHALL discard the in-flight job with no result pushed.
REQ-025 Output values in reset: data_o=0, irq_o=0, STATUS=32'h00000004.

Configuration
REQ-026 Macro PLUGIN_MMIO_IRQ_EN defined: IRQCTL bit0 = irq_en (R/W); irq_o = irq_en && (res_valid || OVF || UDF), registered.
REQ-027 Macro not defined: IRQCTL reads 0, writes are ignored, and irq_o is tied 0.

Verification
REQ-028 OPA=5, OPB=7, CMD=0 -> after LATENCY+2 edges STATUS bit3=1; RESULT read returns 12; STATUS then 32'h00000004.
REQ-029 OPA=0x80000000, OPB=0x80000000, CMD=0 -> RESULT=0 (wrap); OPA=1, OPB=2, CMD=1 -> RESULT=0xFFFFFFFF; OPA=1, OPB=0x23, CMD=5 -> RESULT=8.
REQ-030 DEPTH=4, no RESULT reads, 10 CMD writes back-to-back -> results 1-4 stored, job FIFO fills, OVF=1, result count=4; then 4 RESULT reads return the jobs in order and the remaining queued jobs then complete.
REQ-031 Read RESULT when empty -> 0 and UDF=1; STATUS write 32'h60 -> OVF=UDF=0.
REQ-032 Assert reset_n low during EXEC -> busy=0, counts 0, no result appears after release.
REQ-033 With PLUGIN_MMIO_IRQ_EN, IRQCTL=1 and one job -> irq_o rises one cycle after res_valid and falls after the final RESULT pop; without the macro, irq_o stays 0 throughout.
